// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state, owner and byte-enable definitions for the memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [3:0] WBE_NONE = 4'b0000;
  localparam logic [3:0] WBE_BYTE = 4'b0001;
  localparam logic [3:0] WBE_HALF = 4'b0011;
  localparam logic [3:0] WBE_WORD = 4'b1111;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - owner selection (DM first, fetch after STARVE_MAX DM wins) and starve_cnt update
module mem_arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic       i_idle,
  input  logic       i_if_req,
  input  logic       i_dm_req,
  input  logic [3:0] i_starve_cnt,
  output logic       o_sel,
  output owner_t     o_owner,
  output logic [3:0] o_starve_nxt
);

  localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

  logic w_if_wins;

  always_comb begin
    w_if_wins    = i_if_req && (!i_dm_req || (i_starve_cnt == LP_MAX));
    o_sel        = i_idle && (i_if_req || i_dm_req);
    o_owner      = w_if_wins ? OWN_IF : OWN_DM;
    o_starve_nxt = i_starve_cnt;
    // The counter only moves while arbitrating; a busy memory freezes it.
    if (i_idle) begin
      if (!i_if_req || w_if_wins) begin
        o_starve_nxt = 4'd0;
      end else if (i_dm_req && (i_starve_cnt != LP_MAX)) begin
        o_starve_nxt = i_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/DM arbiter for the single-ported unified memory
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_wbe,
  output logic        o_dm_gnt,
  output logic        o_dm_rvalid,
  output logic [31:0] o_dm_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wbe,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] o_perf_if_cnt,
  output logic [31:0] o_perf_dm_cnt,
  output logic [31:0] o_perf_conflict_cnt
`endif
);

  arb_state_t  r_state;
  owner_t      r_owner;
  logic [3:0]  r_starve_cnt;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wbe;
  logic        r_if_rvalid;
  logic        r_dm_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic        w_idle;
  logic        w_sel;
  owner_t      w_owner;
  logic [3:0]  w_starve_nxt;
  logic        w_accept;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = (r_state == ISSUE) && i_mem_ready;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .i_idle      (w_idle),
    .i_if_req    (i_if_req),
    .i_dm_req    (i_dm_req),
    .i_starve_cnt(r_starve_cnt),
    .o_sel       (w_sel),
    .o_owner     (w_owner),
    .o_starve_nxt(w_starve_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IF;
      r_starve_cnt <= 4'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_wbe    <= WBE_NONE;
      r_if_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_if_rdata   <= 32'd0;
      r_dm_rdata   <= 32'd0;
    end else begin
      r_if_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_starve_cnt <= w_starve_nxt;
      case (r_state)
        IDLE: begin
          if (w_sel) begin
            r_owner   <= w_owner;
            r_mem_req <= 1'b1;
            r_state   <= ISSUE;
            if (w_owner == OWN_DM) begin
              r_mem_we    <= i_dm_we;
              r_mem_addr  <= i_dm_addr;
              r_mem_wdata <= i_dm_wdata;
              r_mem_wbe   <= i_dm_wbe;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= i_if_addr;
              r_mem_wdata <= 32'd0;
              r_mem_wbe   <= WBE_NONE;
            end
          end
        end
        ISSUE: begin
          // Stores retire on acceptance; loads still owe read data.
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= r_mem_we ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            r_state <= IDLE;
            if (r_owner == OWN_IF) begin
              r_if_rdata  <= i_mem_rdata;
              r_if_rvalid <= 1'b1;
            end else begin
              r_dm_rdata  <= i_mem_rdata;
              r_dm_rvalid <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_if_gnt    = w_accept && (r_owner == OWN_IF);
  assign o_dm_gnt    = w_accept && (r_owner == OWN_DM);
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rvalid = r_dm_rvalid;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wbe   = r_mem_wbe;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_if_cnt;
  logic [31:0] r_perf_dm_cnt;
  logic [31:0] r_perf_conflict_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_if_cnt       <= 32'd0;
      r_perf_dm_cnt       <= 32'd0;
      r_perf_conflict_cnt <= 32'd0;
    end else begin
      if (o_if_gnt) r_perf_if_cnt <= r_perf_if_cnt + 32'd1;
      if (o_dm_gnt) r_perf_dm_cnt <= r_perf_dm_cnt + 32'd1;
      if (w_idle && i_if_req && i_dm_req) r_perf_conflict_cnt <= r_perf_conflict_cnt + 32'd1;
    end
  end

  assign o_perf_if_cnt       = r_perf_if_cnt;
  assign o_perf_dm_cnt       = r_perf_dm_cnt;
  assign o_perf_conflict_cnt = r_perf_conflict_cnt;
`endif

endmodule
